// File: rtl/fpu_defs_pkg.sv
// fpu_defs: shared widths, flag bit positions and result beat type for the FPU wrapper
package fpu_defs;
  localparam int C_OP = 32;
  localparam int C_TAG = 4;
  localparam int C_FLAG_US = 9;
  localparam int C_FFLAGS = 5;
  localparam int FLAG_OF = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_IX = 5;
  localparam int FLAG_IV = 6;
  localparam int FLAG_INF = 7;
  typedef struct packed {
    logic [C_OP-1:0]      data;
    logic [C_FLAG_US-1:0] flags;
    logic [C_TAG-1:0]     tag;
  } fpu_res_t;
endpackage

// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo: result beat storage with registered pointers and occupancy; push into a full FIFO succeeds only alongside a pop
module fpu_result_fifo
  import fpu_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic                       push,
  input  logic                       pop,
  input  fpu_res_t                   wdata,
  output fpu_res_t                   rdata,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fpu_res_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = occupancy == CW'(DEPTH);
  assign empty = occupancy == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // head is muxed by the registered read pointer and forced to zero while empty
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      occupancy <= occupancy + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge Clk_CI) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: queues FPU result beats for the core, issues credits upstream and accumulates sticky fflags
module fpu_result_buffer
  import fpu_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic                       IssueValid_SI,
  output logic                       IssueReady_SO,
  input  logic                       ResValid_SI,
  input  logic [C_OP-1:0]            ResData_DI,
  input  logic [C_FLAG_US-1:0]       ResFlags_SI,
  input  logic [C_TAG-1:0]           ResTag_DI,
  output logic                       OutValid_SO,
  input  logic                       OutReady_SI,
  output logic [C_OP-1:0]            OutData_DO,
  output logic [C_FLAG_US-1:0]       OutFlags_SO,
  output logic [C_TAG-1:0]           OutTag_DO,
  input  logic                       FFlagsClear_SI,
  output logic [C_FFLAGS-1:0]        FFlags_SO,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy_SO,
  output logic                       Error_SO
);
  localparam int CW = $clog2(DEPTH+1);
  fpu_res_t beat, head;
  logic full, empty, issue_fire, pop_fire, orphan, drop, dec;
  logic [CW-1:0] in_flight;
  logic [CW:0] load;
  logic [C_FFLAGS-1:0] head_ff;
  assign beat = '{data: ResData_DI, flags: ResFlags_SI, tag: ResTag_DI};
  fpu_result_fifo #(.DEPTH(DEPTH)) i_fifo (
    .Clk_CI    (Clk_CI),
    .Rst_RI    (Rst_RI),
    .push      (ResValid_SI),
    .pop       (OutReady_SI),
    .wdata     (beat),
    .rdata     (head),
    .occupancy (Occupancy_SO),
    .full      (full),
    .empty     (empty)
  );
  // credits count both queued and outstanding results so the FIFO can never be overrun
  assign load = {1'b0, in_flight} + {1'b0, Occupancy_SO};
  assign IssueReady_SO = load < (CW+1)'(DEPTH);
  assign issue_fire = IssueValid_SI & IssueReady_SO;
  assign pop_fire = ~empty & OutReady_SI;
  assign orphan = ResValid_SI & (in_flight == '0);
  assign drop = ResValid_SI & full & ~pop_fire;
  assign dec = ResValid_SI & ((in_flight != '0) | issue_fire);
  assign head_ff = {head.flags[FLAG_IV], 1'b0, head.flags[FLAG_OF], head.flags[FLAG_UF], head.flags[FLAG_IX]};
  assign OutValid_SO = ~empty;
  assign OutData_DO = head.data;
  assign OutFlags_SO = head.flags;
  assign OutTag_DO = head.tag;
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      in_flight <= '0;
      Error_SO <= 1'b0;
      FFlags_SO <= '0;
    end else begin
      in_flight <= in_flight + CW'(issue_fire) - CW'(dec);
      Error_SO <= Error_SO | orphan | drop;
      FFlags_SO <= (FFlagsClear_SI ? '0 : FFlags_SO) | (pop_fire ? head_ff : '0);
    end
  end
endmodule
